// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every input vector of a combinational DUT
// in ascending order, samples its single output after a settle time and scores it.
module truth_table_checker #(
  parameter int unsigned          N_IN          = 3,
  parameter logic [(2**N_IN)-1:0] EXPECTED      = 8'hE8,
  parameter int unsigned          SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [N_IN-1:0]          vec_out,
  input  logic                     y_in,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_count,
  output logic [(2**N_IN)-1:0]     fail_mask,
  output logic [N_IN-1:0]          case_idx
);

  localparam int unsigned N_CASES = 2 ** N_IN;
  localparam int unsigned IDX_W   = N_IN;
  localparam int unsigned ERR_W   = N_IN + 1;
  localparam int unsigned CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CASES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [N_CASES-1:0]   mask_q, mask_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 mismatch;
  logic [1:0]           rst_sync;
  logic                 rst_sync_n;

  // Assertion is immediate; release is re-timed to clk through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Case inequality so an X/Z from the DUT in simulation scores as a miss.
  assign mismatch = (y_in !== EXPECTED[idx_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mask_d  = mask_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          mask_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      ST_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (mismatch) begin
          err_d         = err_q + ERR_W'(1);
          mask_d[idx_q] = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_WAIT;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign vec_out   = idx_q;
  assign case_idx  = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a behavioural DUT model drives y_in
// from vec_out; a second instance covers a 2-input XOR with one settle cycle.
module tb_truth_table_checker;

  localparam int M_MAJ   = 0;
  localparam int M_ZERO  = 1;
  localparam int M_ONE   = 2;
  localparam int M_CASE5 = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] vec_out;
  logic       y_in;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [7:0] fail_mask;
  logic [2:0] case_idx;

  logic       start2 = 1'b0;
  logic [1:0] vec2;
  logic       y2;
  logic       busy2, done2, pass2;
  logic [2:0] err2;
  logic [3:0] mask2;
  logic [1:0] idx2;

  int   mode = M_MAJ;
  logic glitch = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  truth_table_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_out(vec_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_mask(fail_mask), .case_idx(case_idx)
  );

  truth_table_checker #(.N_IN(2), .EXPECTED(4'b0110), .SETTLE_CYCLES(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vec_out(vec2), .y_in(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_mask(mask2), .case_idx(idx2)
  );

  function automatic logic dut_y(input int m, input logic [2:0] v);
    logic maj;
    maj = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    case (m)
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      M_CASE5: return (v == 3'd5) ? 1'b0 : maj;
      default: return maj;
    endcase
  endfunction

  always_comb y_in = dut_y(mode, vec_out) ^ glitch;
  assign y2 = vec2[1] ^ vec2[0];

  // Leaves the caller at the negedge right after the edge that took start.
  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests++;
    if ({vec_out, busy, done, pass, err_count, fail_mask, case_idx} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h required 0",
               {vec_out, busy, done, pass, err_count, fail_mask, case_idx});
    end
    tests++;
    if ({vec2, busy2, done2, pass2, err2, mask2, idx2} !== '0) begin
      fails++;
      $display("FAIL reset_outputs2: got %0h required 0",
               {vec2, busy2, done2, pass2, err2, mask2, idx2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_majority;
    mode = M_MAJ;
    pulse_start();
    for (int c = 0; c < 24; c++) begin
      tests++;
      if (vec_out !== 3'(c / 3) || case_idx !== 3'(c / 3)) begin
        fails++;
        $display("FAIL maj_vec c=%0d: got %0d/%0d required %0d", c, vec_out, case_idx, c / 3);
      end
      tests++;
      if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) begin
        fails++;
        $display("FAIL maj_busy c=%0d: got busy=%b done=%b pass=%b required 1/0/0",
                 c, busy, done, pass);
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b1 || err_count !== 4'd0 ||
        fail_mask !== 8'h00 || vec_out !== 3'd7) begin
      fails++;
      $display("FAIL maj_result: got done=%b busy=%b pass=%b err=%0d mask=%h vec=%0d required 1/0/1/0/00/7",
               done, busy, pass, err_count, fail_mask, vec_out);
    end
  endtask

  task automatic test_stuck;
    mode = M_ZERO;
    pulse_start();
    repeat (24) @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 4'd4 || fail_mask !== 8'hE8) begin
      fails++;
      $display("FAIL stuck0: got done=%b pass=%b err=%0d mask=%h required 1/0/4/e8",
               done, pass, err_count, fail_mask);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1'b1 || err_count !== 4'd4 || fail_mask !== 8'hE8 || vec_out !== 3'd7) begin
      fails++;
      $display("FAIL stuck0_hold: got done=%b err=%0d mask=%h vec=%0d required 1/4/e8/7",
               done, err_count, fail_mask, vec_out);
    end
    mode = M_ONE;
    pulse_start();
    repeat (24) @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 4'd4 || fail_mask !== 8'h17) begin
      fails++;
      $display("FAIL stuck1: got done=%b pass=%b err=%0d mask=%h required 1/0/4/17",
               done, pass, err_count, fail_mask);
    end
  endtask

  // Inverts y_in on every cycle whose closing edge is a WAIT edge.
  task automatic test_single_fault;
    mode = M_CASE5;
    pulse_start();
    for (int c = 0; c < 24; c++) begin
      glitch = ((c + 1) % 3 != 0);
      @(negedge clk);
    end
    glitch = 1'b0;
    tests++;
    if (done !== 1'b1 || pass !== 1'b0 || err_count !== 4'd1 || fail_mask !== 8'h20) begin
      fails++;
      $display("FAIL case5_glitch: got done=%b pass=%b err=%0d mask=%h required 1/0/1/20",
               done, pass, err_count, fail_mask);
    end
  endtask

  task automatic test_back_to_back;
    mode = M_ZERO;
    pulse_start();
    for (int c = 0; c < 24; c++) begin
      start = (c == 4);
      if (c == 23) begin
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL restart_ignored_c23: got done=%b busy=%b required 0/1", done, busy);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || err_count !== 4'd4 || fail_mask !== 8'hE8) begin
      fails++;
      $display("FAIL restart_ignored: got done=%b err=%0d mask=%h required 1/4/e8",
               done, err_count, fail_mask);
    end
    mode = M_MAJ;
    @(negedge clk);
    pulse_start();
    tests++;
    if (done !== 1'b0 || busy !== 1'b1 || err_count !== 4'd0 || fail_mask !== 8'h00 ||
        vec_out !== 3'd0) begin
      fails++;
      $display("FAIL done_restart: got done=%b busy=%b err=%0d mask=%h vec=%0d required 0/1/0/00/0",
               done, busy, err_count, fail_mask, vec_out);
    end
    repeat (24) @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || err_count !== 4'd0) begin
      fails++;
      $display("FAIL second_sweep: got done=%b pass=%b err=%0d required 1/1/0",
               done, pass, err_count);
    end
  endtask

  task automatic test_async_reset;
    mode = M_ZERO;
    pulse_start();
    repeat (13) @(negedge clk);
    tests++;
    if (vec_out !== 3'd4) begin
      fails++;
      $display("FAIL pre_reset_idx: got %0d required 4", vec_out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({vec_out, busy, done, pass, err_count, fail_mask, case_idx} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %0h required 0",
               {vec_out, busy, done, pass, err_count, fail_mask, case_idx});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mode = M_MAJ;
    pulse_start();
    tests++;
    if (vec_out !== 3'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL post_reset_start: got vec=%0d busy=%b required 0/1", vec_out, busy);
    end
    repeat (23) @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_early: got done=%b required 0", done);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || pass !== 1'b1 || fail_mask !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_sweep: got done=%b pass=%b mask=%h required 1/1/00",
               done, pass, fail_mask);
    end
  endtask

  task automatic test_xor2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tests++;
      if (vec2 !== 2'(c / 2) || done2 !== 1'b0 || busy2 !== 1'b1) begin
        fails++;
        $display("FAIL xor2_step c=%0d: got vec=%0d done=%b busy=%b required %0d/0/1",
                 c, vec2, done2, busy2, c / 2);
      end
      @(negedge clk);
    end
    tests++;
    if (done2 !== 1'b1 || pass2 !== 1'b1 || err2 !== 3'd0 || mask2 !== 4'h0 || idx2 !== 2'd3) begin
      fails++;
      $display("FAIL xor2_result: got done=%b pass=%b err=%0d mask=%h idx=%0d required 1/1/0/0/3",
               done2, pass2, err2, mask2, idx2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_majority();
    test_stuck();
    test_single_fault();
    test_back_to_back();
    test_async_reset();
    test_xor2();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Hardware counterpart of the lab exhaustive-stimulus benches: the checking end that sits opposite a combinational DUT.
- Drives every input combination to the DUT in ascending binary order, waits a fixed settle time, samples the DUT's single-bit output and compares it against a parameterised expected truth table.
- Reports pass/fail, mismatch count and a per-case failure mask, so lab parts can be checked on a board with LEDs instead of `$display`.

Parameters:
- N_IN, 3, number of DUT inputs; 2**N_IN cases; legal range 1..6.
- EXPECTED, 8'hE8, expected output per case; bit i is Y for input vector i; width 2**N_IN.
- SETTLE_CYCLES, 2, cycles the vector is held before sampling; must be ≥1.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a sweep.
- vec_out, output, N_IN, input vector driven to the DUT; MSB = first DUT input (A).
- y_in, input, 1, DUT output under test.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, high once a sweep completes; holds until the next start or reset.
- pass, output, 1, valid while done=1; 1 iff err_count==0.
- err_count, output, N_IN+1, number of mismatching cases.
- fail_mask, output, 2**N_IN, bit i set iff case i mismatched.
- case_idx, output, N_IN, index of the case currently applied; equals vec_out.

Behaviour:
- Single clock domain: clk.
- Reset: rst_n is asynchronous and active-low. While low, all outputs are 0 and the FSM is in IDLE. Deassertion is synchronised internally; the first active edge follows the deassertion.
- FSM states: IDLE, WAIT, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: clear err_count and fail_mask; set idx=0, vec_out=0, settle counter=0, busy=1; go to WAIT.
- WAIT:
  - Hold vec_out and increment the settle counter each cycle.
  - When counter==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - Compare y_in against EXPECTED[idx].
  - On mismatch: err_count+1 and fail_mask[idx]=1.
  - In simulation, a y_in of X or Z counts as a mismatch (case-inequality compare).
  - If idx==2**N_IN-1: go to DONE, busy=0, done=1, pass=(final err_count==0).
  - Otherwise: idx+1, vec_out=idx+1, counter=0; go to WAIT.
- DONE:
  - Results hold and vec_out holds the last vector.
  - start=1: identical to start from IDLE (clear results, done=0, busy=1, go to WAIT).
- Latency:
  - Each case occupies SETTLE_CYCLES+1 cycles; vec_out changes only on leaving SAMPLE.
  - With start sampled at edge k, done rises at edge k + 2**N_IN*(SETTLE_CYCLES+1).
  - Defaults: 24 cycles.
- Boundary conditions:
  - start while busy=1: ignored; the sweep continues unaffected.
  - start held high: only the edge taken in IDLE/DONE starts a sweep. After completion DONE is entered; if start is still high at the next edge, a new sweep starts (level-sensitive in DONE).
  - err_count width N_IN+1 holds the maximum count 2**N_IN with no overflow.
  - idx does not wrap past the last case.
  - Reset mid-sweep: immediate return to IDLE with all outputs 0; partial results are discarded.
  - pass and err_count are meaningful only when done=1. While busy they show running values, and pass is held 0.

Test Plan:
1. Majority-function DUT model (Y=AB+AC+BC) on y_in, defaults, pulse start → vec_out steps 0..7, each value held 3 cycles; done rises 24 cycles after start; pass=1, err_count=0, fail_mask=8'h00.
2. y_in tied 0 → done=1, pass=0, err_count=4, fail_mask=8'hE8. y_in tied 1 → err_count=4, fail_mask=8'h17.
3. DUT with case 5 inverted (Y=0 at ABC=101) → err_count=1, fail_mask=8'h20, pass=0. Confirm y_in is sampled only in the SAMPLE cycle: a glitch on y_in during WAIT cycles must not count.
4. Pulse start at cycle 5 of a running sweep → no restart; done still at cycle 24 with correct results. Then pulse start in DONE with a good DUT → results cleared, done=0 next cycle, second sweep passes.
5. Assert rst_n low asynchronously mid-sweep at idx=4 → all outputs 0 immediately without waiting for a clock edge; after release, start → full 24-cycle sweep from vec_out=0.
6. SETTLE_CYCLES=1, N_IN=2, EXPECTED=4'b0110 with an XOR DUT → each vector held 2 cycles; done 8 cycles after start; pass=1.
